// File: rtl/ahb_bm_pkg.sv
// Shared AHB bus-matrix definitions: transfer/response encodings, default address width
// and the address-phase control bundle captured by the input stages.
package ahb_bm_pkg;

    localparam int AHB_ADDR_W = 32;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic {
        NO_PEND = 1'b0,
        PEND    = 1'b1
    } pend_state_e;

    typedef struct packed {
        logic [1:0] trans;
        logic       write;
        logic [2:0] size;
        logic [2:0] burst;
        logic [3:0] prot;
        logic       lock;
    } ahb_ctrl_t;

endpackage

// File: rtl/ahb_bm_hold_reg.sv
// Enable-loaded copy of one address phase, used while the master waits for its grant.
module ahb_bm_hold_reg
    import ahb_bm_pkg::*;
#(
    parameter int ADDR_W = AHB_ADDR_W
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_addr,
    input  ahb_ctrl_t         i_ctrl,
    output logic [ADDR_W-1:0] o_addr,
    output ahb_ctrl_t         o_ctrl
);

    logic [ADDR_W-1:0] r_addr;
    ahb_ctrl_t         r_ctrl;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_addr <= '0;
            r_ctrl <= '0;
        end else if (i_load) begin
            r_addr <= i_addr;
            r_ctrl <= i_ctrl;
        end
    end

    assign o_addr = r_addr;
    assign o_ctrl = r_ctrl;

endmodule

// File: rtl/ahb_bm_input_stage.sv
// Per-master input stage of the AHB bus matrix: requests the slave port, holds the
// address phase while ungranted and stalls the master, and relays slave responses.
module ahb_bm_input_stage
    import ahb_bm_pkg::*;
#(
    parameter int ADDR_W = AHB_ADDR_W
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              HSELS,
    input  logic [ADDR_W-1:0] HADDRS,
    input  logic [1:0]        HTRANSS,
    input  logic              HWRITES,
    input  logic [2:0]        HSIZES,
    input  logic [2:0]        HBURSTS,
    input  logic [3:0]        HPROTS,
    input  logic              HMASTLOCKS,
    input  logic              HREADYS,
    input  logic              active_trans,
    input  logic              HREADYM,
    input  logic              HRESPM,
    output logic              trans_valid,
    output logic [ADDR_W-1:0] HADDRM,
    output logic [1:0]        HTRANSM,
    output logic              HWRITEM,
    output logic [2:0]        HSIZEM,
    output logic [2:0]        HBURSTM,
    output logic [3:0]        HPROTM,
    output logic              HMASTLOCKM,
    output logic              HREADYOUTS,
    output logic              HRESPS
);

    pend_state_e       r_state;
    pend_state_e       w_next_state;
    logic              r_dphase;
    logic              w_live;
    logic              w_pend;
    logic              w_accept;
    logic              w_load;
    ahb_ctrl_t         w_ctrl_live;
    ahb_ctrl_t         w_ctrl_held;
    ahb_ctrl_t         w_ctrl_out;
    logic [ADDR_W-1:0] w_addr_held;

    // Gated by reset so nothing is requested or issued while HRESETn is low.
    assign w_live      = HRESETn & HSELS & HTRANSS[1] & HREADYS;
    assign w_pend      = (r_state == PEND);
    assign trans_valid = w_pend | w_live;
    assign w_accept    = trans_valid & active_trans & HREADYM;
    assign w_load      = ~w_pend & w_live & ~w_accept;

    assign w_ctrl_live = '{trans: HTRANSS, write: HWRITES, size: HSIZES,
                           burst: HBURSTS, prot: HPROTS, lock: HMASTLOCKS};

    ahb_bm_hold_reg #(
        .ADDR_W (ADDR_W)
    ) u_hold_reg (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .i_load  (w_load),
        .i_addr  (HADDRS),
        .i_ctrl  (w_ctrl_live),
        .o_addr  (w_addr_held),
        .o_ctrl  (w_ctrl_held)
    );

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state <= NO_PEND;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            NO_PEND: if (w_live && !w_accept) w_next_state = PEND;
            PEND:    if (w_accept)            w_next_state = NO_PEND;
            default:                          w_next_state = NO_PEND;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_dphase <= 1'b0;
        end else if (w_accept) begin
            r_dphase <= 1'b1;
        end else if (HREADYM) begin
            r_dphase <= 1'b0;
        end
    end

    // While pending the master is stalled, so the held copy is the only valid phase.
    always_comb begin
        HADDRM           = HADDRS;
        w_ctrl_out       = w_ctrl_live;
        w_ctrl_out.trans = w_live ? HTRANSS : HTRANS_IDLE;
        if (w_pend) begin
            HADDRM     = w_addr_held;
            w_ctrl_out = w_ctrl_held;
        end
    end

    assign HTRANSM    = w_ctrl_out.trans;
    assign HWRITEM    = w_ctrl_out.write;
    assign HSIZEM     = w_ctrl_out.size;
    assign HBURSTM    = w_ctrl_out.burst;
    assign HPROTM     = w_ctrl_out.prot;
    assign HMASTLOCKM = w_ctrl_out.lock;

    always_comb begin
        HREADYOUTS = 1'b1;
        HRESPS     = HRESP_OKAY;
        if (w_pend) begin
            HREADYOUTS = 1'b0;
        end else if (r_dphase) begin
            HREADYOUTS = HREADYM;
            HRESPS     = HRESPM;
        end
    end

endmodule

// File: tb/tb_ahb_bm_input_stage.sv
// Directed bench for ahb_bm_input_stage: pass-through, held transfers, error relay,
// locked bursts and asynchronous reset during a held transfer.
module tb_ahb_bm_input_stage;
    import ahb_bm_pkg::*;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        HSELS;
    logic [31:0] HADDRS;
    logic [1:0]  HTRANSS;
    logic        HWRITES;
    logic [2:0]  HSIZES;
    logic [2:0]  HBURSTS;
    logic [3:0]  HPROTS;
    logic        HMASTLOCKS;
    logic        HREADYS;
    logic        active_trans;
    logic        HREADYM;
    logic        HRESPM;
    logic        trans_valid;
    logic [31:0] HADDRM;
    logic [1:0]  HTRANSM;
    logic        HWRITEM;
    logic [2:0]  HSIZEM;
    logic [2:0]  HBURSTM;
    logic [3:0]  HPROTM;
    logic        HMASTLOCKM;
    logic        HREADYOUTS;
    logic        HRESPS;

    int n_checks = 0;
    int n_errors = 0;

    always #5 HCLK = ~HCLK;

    // Master-side HREADY is the stage's own HREADYOUTS, as in the real matrix.
    assign HREADYS = HREADYOUTS;

    ahb_bm_input_stage #(.ADDR_W(32)) dut (
        .HCLK         (HCLK),
        .HRESETn      (HRESETn),
        .HSELS        (HSELS),
        .HADDRS       (HADDRS),
        .HTRANSS      (HTRANSS),
        .HWRITES      (HWRITES),
        .HSIZES       (HSIZES),
        .HBURSTS      (HBURSTS),
        .HPROTS       (HPROTS),
        .HMASTLOCKS   (HMASTLOCKS),
        .HREADYS      (HREADYS),
        .active_trans (active_trans),
        .HREADYM      (HREADYM),
        .HRESPM       (HRESPM),
        .trans_valid  (trans_valid),
        .HADDRM       (HADDRM),
        .HTRANSM      (HTRANSM),
        .HWRITEM      (HWRITEM),
        .HSIZEM       (HSIZEM),
        .HBURSTM      (HBURSTM),
        .HPROTM       (HPROTM),
        .HMASTLOCKM   (HMASTLOCKM),
        .HREADYOUTS   (HREADYOUTS),
        .HRESPS       (HRESPS)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven from there.
    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic master_idle();
        HSELS      = 1'b0;
        HTRANSS    = HTRANS_IDLE;
        HWRITES    = 1'b0;
        HSIZES     = 3'd0;
        HBURSTS    = 3'd0;
        HPROTS     = 4'd0;
        HMASTLOCKS = 1'b0;
    endtask

    initial begin
        HRESETn      = 1'b0;
        HADDRS       = 32'h0;
        active_trans = 1'b0;
        HREADYM      = 1'b1;
        HRESPM       = 1'b0;
        master_idle();

        // Reset state
        settle();
        check("rst_hreadyouts", HREADYOUTS, 1);
        check("rst_hresps", HRESPS, 0);
        check("rst_trans_valid", trans_valid, 0);
        check("rst_htransm", HTRANSM, HTRANS_IDLE);
        tick();
        tick();
        HRESETn = 1'b1;
        tick();
        settle();
        check("idle_trans_valid", trans_valid, 0);
        check("idle_hreadyouts", HREADYOUTS, 1);
        check("idle_htransm", HTRANSM, HTRANS_IDLE);

        // Granted NONSEQ write passes straight through
        HSELS = 1'b1; HADDRS = 32'h0000_1000; HTRANSS = HTRANS_NONSEQ; HWRITES = 1'b1;
        active_trans = 1'b1; HREADYM = 1'b1;
        settle();
        check("wr_haddrm", HADDRM, 32'h0000_1000);
        check("wr_htransm", HTRANSM, HTRANS_NONSEQ);
        check("wr_hwritem", HWRITEM, 1);
        check("wr_trans_valid", trans_valid, 1);
        check("wr_hreadyouts", HREADYOUTS, 1);
        tick();
        master_idle(); HADDRS = 32'h0; active_trans = 1'b0; HREADYM = 1'b0;
        settle();
        check("wr_dph_wait", HREADYOUTS, 0);
        check("wr_dph_trans_valid", trans_valid, 0);
        check("wr_dph_htransm", HTRANSM, HTRANS_IDLE);
        tick();
        HREADYM = 1'b1;
        settle();
        check("wr_dph_done", HREADYOUTS, 1);
        tick();

        // Ungranted NONSEQ read is held for three cycles
        HSELS = 1'b1; HADDRS = 32'h2000_0040; HTRANSS = HTRANS_NONSEQ; HWRITES = 1'b0;
        active_trans = 1'b0; HREADYM = 1'b1;
        settle();
        check("rd_req", trans_valid, 1);
        check("rd_first_ready", HREADYOUTS, 1);
        tick();
        HTRANSS = HTRANS_IDLE;
        for (int i = 0; i < 3; i++) begin
            HADDRS = 32'h3333_0000 + 32'(i);
            settle();
            check("rd_pend_hreadyouts", HREADYOUTS, 0);
            check("rd_pend_haddrm", HADDRM, 32'h2000_0040);
            check("rd_pend_htransm", HTRANSM, HTRANS_NONSEQ);
            check("rd_pend_trans_valid", trans_valid, 1);
            check("rd_pend_hresps", HRESPS, HRESP_OKAY);
            tick();
        end
        active_trans = 1'b1;
        settle();
        check("rd_grant_haddrm", HADDRM, 32'h2000_0040);
        check("rd_grant_hwritem", HWRITEM, 0);
        check("rd_grant_hreadyouts", HREADYOUTS, 0);
        tick();
        active_trans = 1'b0; HSELS = 1'b0; HREADYM = 1'b0;
        settle();
        check("rd_dph_wait", HREADYOUTS, 0);
        check("rd_dph_trans_valid", trans_valid, 0);
        tick();
        HREADYM = 1'b1;
        settle();
        check("rd_dph_done", HREADYOUTS, 1);
        tick();

        // Granted transfer answered with a two-cycle ERROR
        HSELS = 1'b1; HADDRS = 32'h4000_0000; HTRANSS = HTRANS_NONSEQ;
        active_trans = 1'b1; HREADYM = 1'b1;
        tick();
        HTRANSS = HTRANS_IDLE; HREADYM = 1'b0; HRESPM = HRESP_ERROR;
        settle();
        check("err1_hresps", HRESPS, HRESP_ERROR);
        check("err1_hreadyouts", HREADYOUTS, 0);
        check("err1_trans_valid", trans_valid, 0);
        tick();
        HREADYM = 1'b1;
        settle();
        check("err2_hresps", HRESPS, HRESP_ERROR);
        check("err2_hreadyouts", HREADYOUTS, 1);
        check("err2_idle_not_req", trans_valid, 0);
        tick();
        HRESPM = HRESP_OKAY;
        settle();
        check("err_after_hresps", HRESPS, HRESP_OKAY);
        master_idle(); active_trans = 1'b0;
        tick();

        // Locked INCR4 held on its first beat
        HSELS = 1'b1; HADDRS = 32'h5000_0000; HTRANSS = HTRANS_NONSEQ; HWRITES = 1'b1;
        HSIZES = 3'd2; HBURSTS = 3'b011; HPROTS = 4'b0011; HMASTLOCKS = 1'b1;
        active_trans = 1'b0; HREADYM = 1'b1;
        settle();
        check("lk_req", trans_valid, 1);
        tick();
        HADDRS = 32'h5000_0004; HTRANSS = HTRANS_SEQ;
        for (int i = 0; i < 2; i++) begin
            settle();
            check("lk_pend_lock", HMASTLOCKM, 1);
            check("lk_pend_haddrm", HADDRM, 32'h5000_0000);
            check("lk_pend_hburstm", HBURSTM, 3'b011);
            check("lk_pend_hprotm", HPROTM, 4'b0011);
            check("lk_pend_hsizem", HSIZEM, 3'd2);
            check("lk_pend_hreadyouts", HREADYOUTS, 0);
            tick();
        end
        active_trans = 1'b1;
        settle();
        check("lk_grant_htransm", HTRANSM, HTRANS_NONSEQ);
        check("lk_grant_lock", HMASTLOCKM, 1);
        tick();
        for (int b = 1; b < 4; b++) begin
            HADDRS = 32'h5000_0000 + 32'(4 * b);
            settle();
            check("lk_beat_trans_valid", trans_valid, 1);
            check("lk_beat_haddrm", HADDRM, 32'h5000_0000 + 32'(4 * b));
            check("lk_beat_htransm", HTRANSM, HTRANS_SEQ);
            check("lk_beat_lock", HMASTLOCKM, 1);
            check("lk_beat_hreadyouts", HREADYOUTS, 1);
            tick();
        end
        master_idle(); active_trans = 1'b0;
        tick();

        // Asynchronous reset while a transfer is held
        HSELS = 1'b1; HADDRS = 32'h6000_0000; HTRANSS = HTRANS_NONSEQ;
        active_trans = 1'b0; HREADYM = 1'b1;
        tick();
        settle();
        check("rp_pend_hreadyouts", HREADYOUTS, 0);
        check("rp_pend_trans_valid", trans_valid, 1);
        #2;
        HRESETn = 1'b0;
        settle();
        check("rp_hreadyouts", HREADYOUTS, 1);
        check("rp_trans_valid", trans_valid, 0);
        check("rp_htransm", HTRANSM, HTRANS_IDLE);
        check("rp_hresps", HRESPS, HRESP_OKAY);
        tick();
        master_idle();
        HRESETn = 1'b1;
        settle();
        check("rp_after_trans_valid", trans_valid, 0);
        check("rp_after_hreadyouts", HREADYOUTS, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
